subcarrier_mapper: RTL

SUBCARRIER_MAPPER -- requirements
Module: subcarrier_mapper

---
 rtl/subcarrier_mapper_pkg.sv | 33 +++
 rtl/subcarrier_mapper_if.sv | 19 +
 rtl/subcarrier_mapper_pilot_lfsr.sv | 20 ++
 rtl/subcarrier_mapper.sv | 120 ++++++++++++
 4 files changed

// File: rtl/subcarrier_mapper_pkg.sv
// Shared definitions for the OFDM subcarrier mapper: bin masks, LTS reference,
// pilot bins, default amplitudes and FSM state encoding.
package subcarrier_mapper_pkg;

    // bit k = FFT bin k; bin 0 is DC, 1..26 positive, 38..63 negative subcarriers
    localparam logic [63:0] SUBCARRIER_MASK = 64'hFFFF_FFC0_07FF_FFFE;
    localparam logic [63:0] PILOT_MASK      = 64'h0200_0800_0020_0080;
    localparam logic [63:0] DATA_MASK       = SUBCARRIER_MASK ^ PILOT_MASK;
    // 1 marks a -1 LTS bin
    localparam logic [63:0] LTS_REF         = 64'h0A60_5300_0056_7D4C;

    localparam logic [5:0] PILOT_BIN_0   = 6'd7;
    localparam logic [5:0] PILOT_BIN_1   = 6'd21;
    localparam logic [5:0] PILOT_BIN_2   = 6'd43;
    localparam logic [5:0] PILOT_BIN_3   = 6'd57;
    localparam logic [5:0] PILOT_NEG_BIN = PILOT_BIN_1;

    localparam logic signed [15:0] DEF_PILOT_AMP = 16'sd8192;
    localparam logic signed [15:0] DEF_LTS_AMP   = 16'sd8192;
    localparam logic [6:0]         LFSR_SEED     = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LTS  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] real_bin(input logic signed [15:0] amp);
        return {amp, 16'h0000};
    endfunction

endpackage

// File: rtl/subcarrier_mapper_if.sv
// Sample streams of the subcarrier mapper; master is the mapper side.
interface subcarrier_mapper_if;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic        sample_in_ready;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic        sample_out_ready;

    modport master (
        input  sample_in, sample_in_strobe, sample_out_ready,
        output sample_in_ready, sample_out, sample_out_strobe
    );

    modport slave (
        output sample_in, sample_in_strobe, sample_out_ready,
        input  sample_in_ready, sample_out, sample_out_strobe
    );
endinterface

// File: rtl/subcarrier_mapper_pilot_lfsr.sv
// Pilot polarity generator, x^7+x^4+1; pol is the bit for the current data symbol.
module pilot_lfsr
    import subcarrier_mapper_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic step,
    output logic pol
);
    logic [6:0] lfsr;

    assign pol = lfsr[6] ^ lfsr[3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     lfsr <= LFSR_SEED;
        else if (load) lfsr <= LFSR_SEED;
        else if (step) lfsr <= {lfsr[5:0], pol};
    end
endmodule

// File: rtl/subcarrier_mapper.sv
// OFDM frequency-domain mapper: optional two-symbol LTS preamble (TX_LTS_EN),
// then data symbols with pilots and nulls, streamed in FFT bin order.
module subcarrier_mapper
    import subcarrier_mapper_pkg::*;
#(
    parameter logic signed [15:0] PILOT_AMP = DEF_PILOT_AMP,
    parameter logic signed [15:0] LTS_AMP   = DEF_LTS_AMP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [15:0]         num_sym,
    subcarrier_mapper_if.master bus,
    output logic                busy,
    output logic                done
);
    localparam logic signed [15:0] PILOT_NEG = -PILOT_AMP;
    localparam logic signed [15:0] LTS_NEG   = -LTS_AMP;

    state_t      state;
    logic [6:0]  cnt;
    logic [15:0] sym_cnt;
    logic [15:0] num_sym_r;
    logic [5:0]  bin;
    logic        is_used, is_pilot, is_data;
    logic        out_free, advance, start_ok;
    logic        lts_last, sym_last, pol;
    logic [31:0] bin_val;

    assign bin      = cnt[5:0];
    assign is_used  = SUBCARRIER_MASK[bin];
    assign is_pilot = PILOT_MASK[bin];
    assign is_data  = DATA_MASK[bin];
    assign lts_last = (cnt == 7'd127);
    assign sym_last = (bin == 6'd63);
    assign busy     = (state != S_IDLE);
    assign start_ok = enable && start && (state == S_IDLE) && !done;

    // the output register can take a new bin when empty or being drained now
    assign out_free = !bus.sample_out_strobe || bus.sample_out_ready;
    assign bus.sample_in_ready = enable && (state == S_DATA) && is_data && out_free;

    always_comb begin
        advance = 1'b0;
        if (enable && out_free) begin
            if (state == S_LTS)       advance = 1'b1;
            else if (state == S_DATA) advance = !is_data || bus.sample_in_strobe;
        end
    end

    always_comb begin
        bin_val = '0;
        if (state == S_LTS) begin
            if (is_used) bin_val = real_bin(LTS_REF[bin] ? LTS_NEG : LTS_AMP);
        end else if (is_pilot) begin
            bin_val = real_bin((pol ^ (bin == PILOT_NEG_BIN)) ? PILOT_NEG : PILOT_AMP);
        end else if (is_data) begin
            bin_val = bus.sample_in;
        end
    end

    pilot_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (start_ok),
        .step  (advance && (state == S_DATA) && sym_last),
        .pol   (pol)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            sym_cnt               <= '0;
            num_sym_r             <= '0;
            bus.sample_out        <= '0;
            bus.sample_out_strobe <= 1'b0;
            done                  <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            if (bus.sample_out_strobe && bus.sample_out_ready)
                bus.sample_out_strobe <= 1'b0;
            if (advance) begin
                bus.sample_out        <= bin_val;
                bus.sample_out_strobe <= 1'b1;
            end
            case (state)
                S_IDLE: if (start_ok) begin
                    num_sym_r <= num_sym;
                    cnt       <= '0;
                    sym_cnt   <= '0;
`ifdef TX_LTS_EN
                    state     <= S_LTS;
`else
                    state     <= (num_sym == 16'd0) ? S_DONE : S_DATA;
`endif
                end
                S_LTS: if (advance) begin
                    cnt <= cnt + 7'd1;
                    if (lts_last) state <= (num_sym_r == 16'd0) ? S_DONE : S_DATA;
                end
                S_DATA: if (advance) begin
                    if (sym_last) begin
                        cnt     <= '0;
                        sym_cnt <= sym_cnt + 16'd1;
                        if (sym_cnt + 16'd1 == num_sym_r) state <= S_DONE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_DONE: if (out_free) begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
